mem_rv: RTL and testbench
=========================

# mem_rv

Single-port, byte-enabled synchronous memory with a valid/ready request channel, a backpressured response channel and a selectable read latency of 1 or 2 cycles. It is the next-generation core/cache backing store. Unlike the plain `en`/`we` memory, it tracks outstanding reads, buffers responses when the consumer stalls, and can sweep the array to zero after reset.

## Interface
- `DW`, 128, data width in bits; multiple of 8, ≥ 8
- `AW`, 16, word address width; depth `WORDS = 1<<AW`
- `RL`, 1, read latency in cycles, 1 or 2; 2 adds an output register after the array
- `clk`  in  1  sole clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_we`  in  DW/8  byte write mask; nonzero = write, zero = read
- `req_addr`  in  AW  word address
- `req_wdata`  in  DW  write data
- `rsp_valid`  out  1  read data available
- `rsp_ready`  in  1  consumer takes data when `rsp_valid && rsp_ready`
- `rsp_rdata`  out  DW  read data, in request order
- `init_done`  out  1  high once the memory is accepting requests

## Operation
- States: INIT, RUN.
  - Reset enters INIT if `MEM_CLEAR_EN` is defined, otherwise RUN.
  - INIT → RUN after the sweep completes.
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `init_done` = 0.
  - Outstanding count = 0, response buffer empty.
  - `rsp_rdata` is don't-care until the first `rsp_valid`.
- Write, on accept: for each i with `req_we[i]`, set `m[addr][8i+:8] = wdata[8i+:8]`. Unmasked bytes are unchanged. No response is generated.
- Read, on accept: `m[addr]` enters an RL-stage pipeline, then a response FIFO of depth `RL+1`.
- Outstanding count:
  - Counts reads in the pipeline plus reads held in the FIFO.
  - +1 on read accept; −1 on response pop; unchanged when both occur in the same cycle.
- `req_ready = (state==RUN) && (outstanding < RL+1)`. It does not depend on `req_valid` or `req_we`. Writes are gated by the same condition.
- Ordering:
  - Responses return strictly in accept order.
  - A read accepted any cycle after a write to the same address returns the written bytes.
  - Read and write cannot coincide because there is one request per cycle.
- Overflow is impossible by construction. A full FIFO with `rsp_ready` = 0 holds data stable and holds `rsp_valid` high.
- Reset during RUN:
  - In-flight reads and FIFO contents are discarded.
  - Array contents are kept, or re-cleared if `MEM_CLEAR_EN` is defined.

## Timing
- Read accepted at edge t, FIFO empty, `rsp_ready` = 1: `rsp_valid` = 1 in the cycle after edge t+RL−1, i.e. visible RL cycles after accept.
- Back-to-back reads with `rsp_ready` held high: one response per cycle, so full throughput.
- `rsp_ready` low: responses are held stable.
  - `req_ready` drops once RL+1 reads are outstanding.
  - `req_ready` rises in the cycle after the first pop.
- `init_done` equals `state==RUN`, registered.
- Without `MEM_CLEAR_EN`: `req_ready`/`init_done` rise in the first cycle after `rst` deasserts.

## Configuration
- `MEM_CLEAR_EN` defined:
  - INIT writes all-zero to address `cnt` each cycle, starting at `cnt` = 0 and incrementing.
  - On `cnt == WORDS-1`, it writes the last word and enters RUN the next cycle. The sweep takes exactly WORDS cycles after reset release.
  - `req_ready` is held 0 during INIT.
  - Reset asserted mid-sweep restarts from 0.
- `MEM_CLEAR_EN` undefined:
  - No sweep counter or INIT state exists.
  - Array contents after power-up are undefined (X in simulation).

## Test plan
- Clear: `MEM_CLEAR_EN`, AW=4.
  - Release `rst`: `init_done` rises after exactly 16 cycles.
  - Reads of addresses 0..15 all return 0.
  - Reset at sweep cycle 7 restarts the full 16-cycle count.
- Byte enables: DW=32.
  - Write 0xAABBCCDD to addr 3 with we=0xF, then 0x11223344 with we=0x5.
  - Read of addr 3 returns 0xAA22CC44.
- Latency, RL=1 and RL=2, `rsp_ready` held 1.
  - Read accepted at cycle 10: `rsp_valid` asserted at cycle 11 and 12 respectively.
  - 8 back-to-back reads give 8 consecutive response cycles, in order.
- Backpressure, RL=2, `rsp_ready` = 0.
  - Exactly 3 reads are accepted, then `req_ready` = 0 and `rsp_rdata` is stable.
  - Raise `rsp_ready`: 3 responses drain in order, and `req_ready` returns the cycle after the first pop.
- Write-then-read: write 0x5A to addr 0x1F at cycle t, read 0x1F at t+1: response is 0x5A.
- Reset mid-operation.
  - Reset with 2 reads outstanding: `rsp_valid` = 0 the next cycle and no stale response appears afterwards.
  - Without `MEM_CLEAR_EN`, previously written data is still readable.

Source files
------------

// File: rtl/mem_rv.sv
// mem_rv: byte-enabled single-port memory, valid/ready request channel, buffered backpressured read responses.
// Latency: RL (1 or 2) cycles from read accept to rsp_valid; one response per cycle while rsp_ready stays high.
// Backpressure: req_ready drops once RL+1 reads are outstanding. Optional zero sweep after reset: MEM_CLEAR_EN.
module mem_rv #(
   parameter int DW = 128,
   parameter int AW = 16,
   parameter int RL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DW/8-1:0]   req_we,
   input  logic [AW-1:0]     req_addr,
   input  logic [DW-1:0]     req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_rdata,
   output logic              init_done
);
   localparam int NB = DW / 8;
   localparam int FD = RL + 1;             // response FIFO depth == max outstanding reads
   localparam int CW = $clog2(FD + 1);
   localparam int PW = $clog2(FD);

   logic [DW-1:0] mem [1<<AW];
   logic          rd_acc, wr_acc, run_nx, clr_we;
   logic [AW-1:0] clr_addr;
   logic [CW-1:0] out_cnt, fcnt;
   logic          p1_vld, pipe_vld;
   logic [DW-1:0] p1_dat, pipe_dat;
   logic [DW-1:0] fifo_mem [FD];
   logic [PW-1:0] rptr, wptr;
   logic          fifo_empty, pop, push, fifo_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
   endfunction

   assign rd_acc = req_valid && req_ready && (req_we == '0);
   assign wr_acc = req_valid && req_ready && (req_we != '0);

`ifdef MEM_CLEAR_EN
   typedef enum logic {INIT, RUN} state_t;
   state_t        state, state_nx;
   logic [AW-1:0] cnt;

   // state register and sweep address; reset always restarts the sweep at word 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == INIT) cnt <= cnt + AW'(1);
      end
   end

   // next state: INIT zeroes one word per cycle and leaves after writing the last one
   always_comb begin
      state_nx = state;
      clr_we   = 1'b0;
      if (state == INIT) begin
         clr_we = 1'b1;
         if (&cnt) state_nx = RUN;
      end
   end

   assign clr_addr = cnt;
   assign run_nx   = (state_nx == RUN);
`else
   assign clr_we   = 1'b0;
   assign clr_addr = '0;
   assign run_nx   = 1'b1;
`endif

   // init_done is the registered RUN indication and also gates request acceptance
   always_ff @(posedge clk) begin
      if (rst) init_done <= 1'b0;
      else     init_done <= run_nx;
   end

   assign req_ready = init_done && (out_cnt < CW'(FD));

   // array: sweep write, byte-masked write, synchronous read into the first pipeline stage
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++)
            if (req_we[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
      if (rd_acc) p1_dat <= mem[req_addr];
   end

   // first pipeline stage valid; the pipeline never stalls because outstanding reads are capped
   always_ff @(posedge clk) begin
      if (rst) p1_vld <= 1'b0;
      else     p1_vld <= rd_acc;
   end

   if (RL == 2) begin : g_oreg
      logic          p2_vld;
      logic [DW-1:0] p2_dat;
      // optional output register after the array
      always_ff @(posedge clk) begin
         if (rst) p2_vld <= 1'b0;
         else     p2_vld <= p1_vld;
         p2_dat <= p1_dat;
      end
      assign pipe_vld = p2_vld;
      assign pipe_dat = p2_dat;
   end else begin : g_noreg
      assign pipe_vld = p1_vld;
      assign pipe_dat = p1_dat;
   end

   // pipeline output bypasses an empty FIFO; otherwise it queues behind older responses
   assign fifo_empty = (fcnt == '0);
   assign rsp_valid  = pipe_vld || !fifo_empty;
   assign rsp_rdata  = fifo_empty ? pipe_dat : fifo_mem[rptr];
   assign pop        = rsp_valid && rsp_ready;
   assign fifo_pop   = pop && !fifo_empty;
   assign push       = pipe_vld && !(fifo_empty && rsp_ready);

   // response FIFO storage
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr] <= pipe_dat;
   end

   // FIFO pointers and occupancy, plus outstanding-read count (pipeline + FIFO)
   always_ff @(posedge clk) begin
      if (rst) begin
         rptr    <= '0;
         wptr    <= '0;
         fcnt    <= '0;
         out_cnt <= '0;
      end else begin
         if (push)     wptr <= ptr_inc(wptr);
         if (fifo_pop) rptr <= ptr_inc(rptr);
         fcnt    <= fcnt + CW'(push) - CW'(fifo_pop);
         out_cnt <= out_cnt + CW'(rd_acc) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_mem_rv.sv
// Directed bench for mem_rv: two instances (RL=1, RL=2, DW=32, AW=5) driven side by side.
// Expected read data comes from a byte-level model and a per-instance scoreboard queue.
module tb_mem_rv;
   logic        clk;
   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [3:0]  req_we    [2];
   logic [4:0]  req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        init_done [2];

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp0 [$];
   logic [31:0] exp1 [$];
   logic [31:0] mdl [2][32];
   logic        acc [2];

   mem_rv #(.DW(32), .AW(5), .RL(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .init_done(init_done[0])
   );

   mem_rv #(.DW(32), .AW(5), .RL(2)) dut2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .init_done(init_done[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // one clock: score responses popped and requests accepted at the coming edge, then advance
   task automatic tick();
      logic [31:0] e;
      for (int i = 0; i < 2; i++) begin
         acc[i] = 1'b0;
         if (!rst) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               if (i == 0) begin
                  if (exp0.size() == 0) chk("unexpected_rsp_rl1", 32'(rsp_valid[i]), 32'd0);
                  else begin
                     e = exp0.pop_front();
                     chk("rsp_data_rl1", rsp_rdata[i], e);
                  end
               end else begin
                  if (exp1.size() == 0) chk("unexpected_rsp_rl2", 32'(rsp_valid[i]), 32'd0);
                  else begin
                     e = exp1.pop_front();
                     chk("rsp_data_rl2", rsp_rdata[i], e);
                  end
               end
            end
            if (req_valid[i] && req_ready[i]) begin
               acc[i] = 1'b1;
               if (req_we[i] == 4'h0) begin
                  if (i == 0) exp0.push_back(mdl[i][req_addr[i]]);
                  else        exp1.push_back(mdl[i][req_addr[i]]);
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (req_we[i][b]) mdl[i][req_addr[i]][8*b +: 8] = req_wdata[i][8*b +: 8];
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (rst) begin
         exp0.delete();
         exp1.delete();
`ifdef MEM_CLEAR_EN
         for (int i = 0; i < 2; i++)
            for (int a = 0; a < 32; a++) mdl[i][a] = 32'h0;
`endif
      end
   endtask

   task automatic drive(input int i, input logic [3:0] we, input logic [4:0] a, input logic [31:0] d);
      req_valid[i] = 1'b1;
      req_we[i]    = we;
      req_addr[i]  = a;
      req_wdata[i] = d;
   endtask

   task automatic both(input logic [3:0] we, input logic [4:0] a, input logic [31:0] d);
      drive(0, we, a, d);
      drive(1, we, a, d);
   endtask

   // hold requests until each instance accepts its own
   task automatic go();
      int n = 0;
      while ((req_valid[0] || req_valid[1]) && n < 40) begin
         tick();
         n++;
         for (int i = 0; i < 2; i++) if (acc[i]) req_valid[i] = 1'b0;
      end
      chk("accept_timeout", 32'(req_valid[0] || req_valid[1]), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0) && n < 40) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(exp0.size() + exp1.size()), 32'd0);
   endtask

   task automatic wait_init(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!init_done[0] && n < 200);
   endtask

   initial begin
      int n;
      int lat [2];
      int vc [2];
      int first [2];
      int last [2];
      int na [2];

      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 4'h0;
         req_addr[i]  = 5'h0;
         req_wdata[i] = 32'h0;
         rsp_ready[i] = 1'b1;
      end
      repeat (3) tick();

      // reset values
      for (int i = 0; i < 2; i++) begin
         chk("reset_req_ready", 32'(req_ready[i]), 32'd0);
         chk("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
         chk("reset_init_done", 32'(init_done[i]), 32'd0);
      end

`ifdef MEM_CLEAR_EN
      // interrupted sweep restarts the full count
      rst = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_init(n);
      chk("sweep_cycles", 32'(n), 32'd32);
      for (int a = 0; a < 32; a++) begin
         drive(0, 4'h0, 5'(a), 32'h0);
         go();
      end
      drain();
`else
      rst = 1'b0;
      wait_init(n);
      chk("init_after_release", 32'(n), 32'd1);
`endif
      chk("init_done_rl2", 32'(init_done[1]), 32'd1);
      chk("ready_idle_rl1", 32'(req_ready[0]), 32'd1);
      chk("ready_idle_rl2", 32'(req_ready[1]), 32'd1);

      // byte enables: expected 0xAA22CC44
      both(4'hF, 5'd3, 32'hAABBCCDD); go();
      both(4'h5, 5'd3, 32'h11223344); go();
      both(4'h0, 5'd3, 32'h0);        go();
      drain();

      // single-read latency
      both(4'h0, 5'd3, 32'h0);
      go();
      lat[0] = 0;
      lat[1] = 0;
      for (int c = 1; c <= 5; c++) begin
         for (int i = 0; i < 2; i++) if (rsp_valid[i] && lat[i] == 0) lat[i] = c;
         tick();
      end
      chk("latency_rl1", 32'(lat[0]), 32'd1);
      chk("latency_rl2", 32'(lat[1]), 32'd2);
      drain();

      // fill words 8..15 with random data
      for (int k = 0; k < 8; k++) begin
         both(4'hF, 5'(8 + k), $urandom);
         go();
      end

      // eight back-to-back reads at full throughput
      for (int i = 0; i < 2; i++) begin
         vc[i] = 0;
         first[i] = -1;
         last[i] = -1;
      end
      for (int c = 0; c < 14; c++) begin
         if (c < 8) both(4'h0, 5'(8 + c), 32'h0);
         else begin
            req_valid[0] = 1'b0;
            req_valid[1] = 1'b0;
         end
         for (int i = 0; i < 2; i++)
            if (rsp_valid[i]) begin
               vc[i]++;
               if (first[i] < 0) first[i] = c;
               last[i] = c;
            end
         tick();
         if (c < 8) begin
            chk("b2b_accept_rl1", 32'(acc[0]), 32'd1);
            chk("b2b_accept_rl2", 32'(acc[1]), 32'd1);
         end
      end
      for (int i = 0; i < 2; i++) begin
         chk("b2b_rsp_count", 32'(vc[i]), 32'd8);
         chk("b2b_rsp_span", 32'(last[i] - first[i] + 1), 32'd8);
      end
      drain();

      // backpressure: only RL+1 reads get in while rsp_ready is low
      rsp_ready[0] = 1'b0;
      rsp_ready[1] = 1'b0;
      na[0] = 0;
      na[1] = 0;
      for (int c = 0; c < 6; c++) begin
         both(4'h0, 5'(8 + c), 32'h0);
         tick();
         for (int i = 0; i < 2; i++) if (acc[i]) na[i]++;
      end
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      chk("bp_accepted_rl1", 32'(na[0]), 32'd2);
      chk("bp_accepted_rl2", 32'(na[1]), 32'd3);
      tick();
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("bp_ready_low", 32'(req_ready[i]), 32'd0);
         chk("bp_valid_held", 32'(rsp_valid[i]), 32'd1);
      end
      chk("bp_hold_data_rl1", rsp_rdata[0], exp0[0]);
      chk("bp_hold_data_rl2", rsp_rdata[1], exp1[0]);
      rsp_ready[0] = 1'b1;
      rsp_ready[1] = 1'b1;
      tick();
      chk("bp_ready_after_pop_rl1", 32'(req_ready[0]), 32'd1);
      chk("bp_ready_after_pop_rl2", 32'(req_ready[1]), 32'd1);
      drain();
      chk("bp_drained_rl1", 32'(rsp_valid[0]), 32'd0);
      chk("bp_drained_rl2", 32'(rsp_valid[1]), 32'd0);

      // write then read of the same word on the next cycle
      both(4'hF, 5'h1F, 32'h0000005A);
      tick();
      chk("wtr_write_accept", 32'(acc[0] && acc[1]), 32'd1);
      both(4'h0, 5'h1F, 32'h0);
      tick();
      chk("wtr_read_accept", 32'(acc[0] && acc[1]), 32'd1);
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      drain();

      // reset with two reads outstanding
      rsp_ready[0] = 1'b0;
      rsp_ready[1] = 1'b0;
      both(4'h0, 5'd3, 32'h0);    go();
      both(4'h0, 5'h1F, 32'h0);   go();
      rst = 1'b1;
      tick();
      chk("rst_rsp_valid_rl1", 32'(rsp_valid[0]), 32'd0);
      chk("rst_rsp_valid_rl2", 32'(rsp_valid[1]), 32'd0);
      rst = 1'b0;
      rsp_ready[0] = 1'b1;
      rsp_ready[1] = 1'b1;
      wait_init(n);
`ifdef MEM_CLEAR_EN
      chk("rst_reinit_cycles", 32'(n), 32'd32);
`else
      chk("rst_reinit_cycles", 32'(n), 32'd1);
`endif
      for (int c = 0; c < 4; c++) begin
         chk("no_stale_rl1", 32'(rsp_valid[0]), 32'd0);
         chk("no_stale_rl2", 32'(rsp_valid[1]), 32'd0);
         tick();
      end
      both(4'h0, 5'd3, 32'h0);
      go();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
